// File: rtl/frame_pkg.sv
// frame_pkg: shared definitions for the frame replay reader.
// State encoding, default frame geometry and RGB8 -> RGB6 bit positions.
package frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } frame_state_t;

  localparam int unsigned FRAME_W_DEF = 240;
  localparam int unsigned FRAME_H_DEF = 160;

  // MSB of each colour byte in a FIFO word {8'b0, R8, G8, B8}; the top six
  // bits of every byte form the RGB6 pixel.
  localparam int unsigned R_MSB = 23;
  localparam int unsigned G_MSB = 15;
  localparam int unsigned B_MSB = 7;
  localparam int unsigned C6_W  = 6;
  localparam int unsigned PIX_W = 3 * C6_W;

endpackage

// File: rtl/pix_skid.sv
// pix_skid: 2-entry valid/ready skid buffer with occupancy output.
// Entry 0 is always the head presented on rd_data; a simultaneous write and
// pop keeps the occupancy unchanged.
module pix_skid
  import frame_pkg::*;
#(
  parameter int unsigned DW = PIX_W
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    occ
);

  logic [DW-1:0] ent0;
  logic [DW-1:0] ent1;
  logic          pop;

  assign rd_valid = (occ != 2'd0);
  assign rd_data  = ent0;
  assign pop      = rd_valid && rd_ready;

  // Storage and occupancy update; a write with occupancy 2 cannot occur
  // because the reader never has more than two words outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ  <= '0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case (occ)
        2'd0: begin
          if (wr_en) begin
            ent0 <= wr_data;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (wr_en && pop) begin
            ent0 <= wr_data;
          end else if (wr_en) begin
            ent1 <= wr_data;
            occ  <= 2'd2;
          end else if (pop) begin
            occ  <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            ent0 <= ent1;
            if (wr_en) ent1 <= wr_data;
            else       occ  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/frame_rd.sv
// frame_rd: replays one frame from the DDR read FIFO as RGB6 pixels with
// x/y coordinates over a valid/ready interface.
// Optional build macro FRAME_RD_UNDERFLOW_CNT_EN adds a saturating
// starvation-cycle counter on underflow_cnt; otherwise it reads as zero.
module frame_rd
  import frame_pkg::*;
#(
  parameter int unsigned FRAME_W = FRAME_W_DEF,
  parameter int unsigned FRAME_H = FRAME_H_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        playback_en,
  output logic        frame_req,
  input  logic [31:0] fifo_data_out,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [17:0] pixel_data,
  output logic [7:0]  pixel_x,
  output logic [7:0]  pixel_y,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        frame_done,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam int unsigned NPIX  = FRAME_W * FRAME_H;
  localparam int unsigned CNT_W = $clog2(NPIX + 1);

  frame_state_t     state;
  frame_state_t     state_nxt;
  logic [CNT_W-1:0] rd_cnt;
  logic             rd_inflight;
  logic [1:0]       skid_occ;
  logic [17:0]      wr_pix;
  logic             accept;
  logic             last_x;
  logic             last_pix;
  logic             starve;
  logic             unused_bits;

  assign wr_pix = {fifo_data_out[R_MSB -: C6_W],
                   fifo_data_out[G_MSB -: C6_W],
                   fifo_data_out[B_MSB -: C6_W]};
  assign unused_bits = &{1'b0, fifo_data_out[31:24], fifo_data_out[17:16],
                         fifo_data_out[9:8], fifo_data_out[1:0]};

  assign accept   = pixel_valid && pixel_ready;
  assign last_x   = (pixel_x == 8'(FRAME_W - 1));
  assign last_pix = last_x && (pixel_y == 8'(FRAME_H - 1));
  assign starve   = (state == ST_STREAM) && pixel_ready && !pixel_valid &&
                    fifo_empty && !rd_inflight;

  pix_skid #(
    .DW(PIX_W)
  ) u_skid (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (rd_inflight),
    .wr_data (wr_pix),
    .rd_ready(pixel_ready),
    .rd_valid(pixel_valid),
    .rd_data (pixel_data),
    .occ     (skid_occ)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; playback_en is only sampled in IDLE and DONE so a
  // frame in progress always completes.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (playback_en) state_nxt = ST_REQ;
      ST_REQ:    state_nxt = ST_STREAM;
      ST_STREAM: if (accept && last_pix) state_nxt = ST_DONE;
      default:   state_nxt = playback_en ? ST_REQ : ST_IDLE;
    endcase
  end

  // Outputs: request/done pulses and FIFO pop gating (at most two words
  // held in skid plus in flight, never past the end of the frame).
  always_comb begin
    frame_req  = (state == ST_REQ);
    frame_done = (state == ST_DONE);
    fifo_rd_en = (state == ST_STREAM) && !fifo_empty &&
                 (rd_cnt < CNT_W'(NPIX)) &&
                 ({1'b0, skid_occ} + {2'b00, rd_inflight} < 3'd2);
  end

  // Popped-word count and the one-cycle read-latency tracker.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt      <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= fifo_rd_en;
      if (state == ST_REQ)  rd_cnt <= '0;
      else if (fifo_rd_en)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // Coordinates of the head pixel, advanced on every accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (state == ST_REQ) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (accept) begin
      if (last_x) begin
        pixel_x <= '0;
        pixel_y <= last_pix ? '0 : pixel_y + 8'd1;
      end else begin
        pixel_x <= pixel_x + 8'd1;
      end
    end
  end

  // Sticky per-frame starvation flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              underflow <= 1'b0;
    else if (state == ST_REQ) underflow <= 1'b0;
    else if (starve)          underflow <= 1'b1;
  end

`ifdef FRAME_RD_UNDERFLOW_CNT_EN
  logic [15:0] ucnt;

  // Saturating count of starvation cycles in the current frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                    ucnt <= '0;
    else if (state == ST_REQ)       ucnt <= '0;
    else if (starve && ucnt != '1)  ucnt <= ucnt + 16'd1;
  end

  assign underflow_cnt = ucnt;
`else
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_rd.sv
// tb_frame_rd: directed self-checking bench for frame_rd on a reduced
// 12x6 frame, with a behavioural read FIFO (one-cycle read latency).
module tb_frame_rd;

  localparam int unsigned W    = 12;
  localparam int unsigned H    = 6;
  localparam int unsigned NPIX = W * H;

  logic        clk;
  logic        resetn;
  logic        playback_en;
  logic        frame_req;
  logic [31:0] fifo_data_out;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [17:0] pixel_data;
  logic [7:0]  pixel_x;
  logic [7:0]  pixel_y;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        frame_done;
  logic        underflow;
  logic [15:0] underflow_cnt;

  frame_rd #(
    .FRAME_W(W),
    .FRAME_H(H)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .playback_en  (playback_en),
    .frame_req    (frame_req),
    .fifo_data_out(fifo_data_out),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .pixel_data   (pixel_data),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .frame_done   (frame_done),
    .underflow    (underflow),
    .underflow_cnt(underflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Word i of frame f; frame 0 starts with the reference conversion word.
  function automatic logic [31:0] word_of(input int unsigned f, input int unsigned i);
    logic [31:0] w;
    if (f == 0 && i == 0) w = 32'h00FC8004;
    else w = {8'(32'hA0 + f), 8'(i * 37 + f), 8'(i * 11 + 3), 8'(i * 3 + f * 7)};
    return w;
  endfunction

  function automatic logic [17:0] pix6(input logic [31:0] w);
    return {w[23:18], w[15:10], w[7:2]};
  endfunction

  // Read FIFO model
  logic [31:0] q[$];
  logic        pop_pend;

  task automatic push_frame(input int unsigned f, input int unsigned from, input int unsigned upto);
    for (int unsigned i = from; i < upto; i++) q.push_back(word_of(f, i));
    fifo_empty = (q.size() == 0);
  endtask

  task automatic push_junk(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) q.push_back(32'hDEAD_0000 + i);
    fifo_empty = (q.size() == 0);
  endtask

  always @(negedge clk) pop_pend = resetn && fifo_rd_en && !fifo_empty;

  always @(posedge clk) begin
    #1;
    if (pop_pend && resetn && q.size() > 0) fifo_data_out = q.pop_front();
    pop_pend   = 1'b0;
    fifo_empty = (q.size() == 0);
  end

  // Output monitor with a small occupancy model of the skid buffer.
  int unsigned req_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned frame_acc = 0;
  int unsigned exp_idx = 0;
  int unsigned cur_f = 0;
  int unsigned occ_m = 0;
  logic        inf_m = 1'b0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_d;
  logic [7:0]  prev_x, prev_y, last_x, last_y;
  logic        acc;

  always @(negedge clk) begin
    if (!resetn) begin
      occ_m      = 0;
      inf_m      = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (frame_req) begin
        cur_f     = req_cnt;
        req_cnt++;
        exp_idx   = 0;
        frame_acc = 0;
      end
      if (frame_done) done_cnt++;
      check("valid_vs_occ", 32'(pixel_valid), 32'(occ_m != 0));
      if (fifo_rd_en) check("rd_gate", 32'((occ_m + 32'(inf_m)) < 2), 32'd1);
      if (prev_stall) begin
        check("stall_data", 32'(pixel_data), 32'(prev_d));
        check("stall_x", 32'(pixel_x), 32'(prev_x));
        check("stall_y", 32'(pixel_y), 32'(prev_y));
      end
      acc = pixel_valid && pixel_ready;
      if (acc) begin
        check("pix_data", 32'(pixel_data), 32'(pix6(word_of(cur_f, exp_idx))));
        check("pix_x", 32'(pixel_x), exp_idx % W);
        check("pix_y", 32'(pixel_y), exp_idx / W);
        if (cur_f == 0 && exp_idx == 0)
          check("rgb_conv", 32'(pixel_data), 32'({6'h3F, 6'h20, 6'h01}));
        last_x = pixel_x;
        last_y = pixel_y;
        exp_idx++;
        frame_acc++;
      end
      prev_stall = pixel_valid && !pixel_ready;
      prev_d     = pixel_data;
      prev_x     = pixel_x;
      prev_y     = pixel_y;
      occ_m      = occ_m + 32'(inf_m) - 32'(acc);
      inf_m      = fifo_rd_en;
    end
  end

  task automatic pulse_play();
    @(negedge clk) playback_en = 1'b1;
    @(negedge clk) playback_en = 1'b0;
  endtask

  task automatic wait_done(input int unsigned max_cyc, input bit rnd);
    int unsigned d0;
    d0 = done_cnt;
    for (int unsigned c = 0; c < max_cyc; c++) begin
      @(posedge clk);
      #1;
      if (rnd) pixel_ready = ($urandom_range(0, 99) < 30);
      if (done_cnt != d0) break;
    end
    pixel_ready = 1'b1;
    if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_req"},   32'(frame_req), 32'd0);
    check({pfx, "_rden"},  32'(fifo_rd_en), 32'd0);
    check({pfx, "_data"},  32'(pixel_data), 32'd0);
    check({pfx, "_x"},     32'(pixel_x), 32'd0);
    check({pfx, "_y"},     32'(pixel_y), 32'd0);
    check({pfx, "_valid"}, 32'(pixel_valid), 32'd0);
    check({pfx, "_done"},  32'(frame_done), 32'd0);
    check({pfx, "_uf"},    32'(underflow), 32'd0);
    check({pfx, "_ufcnt"}, 32'(underflow_cnt), 32'd0);
  endtask

  initial begin
    int unsigned k;
    int unsigned exp_ucnt;
    bit          hit;

    resetn        = 1'b0;
    playback_en   = 1'b0;
    pixel_ready   = 1'b0;
    fifo_empty    = 1'b1;
    fifo_data_out = '0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    resetn = 1'b1;

    // Single frame, one-cycle playback pulse, extra words must stay queued
    pixel_ready = 1'b1;
    push_frame(0, 0, NPIX);
    push_junk(2);
    pulse_play();
    wait_done(4000, 1'b0);
    check("f0_accepts", frame_acc, NPIX);
    check("f0_last_x", 32'(last_x), W - 1);
    check("f0_last_y", 32'(last_y), H - 1);
    check("f0_req_cnt", req_cnt, 32'd1);
    check("f0_done_cnt", done_cnt, 32'd1);
    check("f0_extra_left", q.size(), 32'd2);
    check("f0_uf", 32'(underflow), 32'd0);
    repeat (5) @(negedge clk);
    check("f0_idle_req", req_cnt, 32'd1);
    check("f0_idle_rden", 32'(fifo_rd_en), 32'd0);
    q.delete();
    fifo_empty = 1'b1;

    // Random 30% ready back-pressure
    push_frame(1, 0, NPIX);
    pulse_play();
    wait_done(8000, 1'b1);
    check("f1_accepts", frame_acc, NPIX);
    check("f1_fifo_left", q.size(), 32'd0);
    check("f1_req_cnt", req_cnt, 32'd2);

    // Starve for exactly 10 cycles mid-frame
    k = NPIX / 2;
    push_frame(2, 0, k);
    pulse_play();
    hit = 1'b0;
    for (int unsigned c = 0; c < 4000; c++) begin
      @(posedge clk);
      if (req_cnt == 3 && frame_acc == k) begin
        hit = 1'b1;
        break;
      end
    end
    check("uf_reach_half", 32'(hit), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("uf_set", 32'(underflow), 32'd1);
    push_frame(2, k, NPIX);
    wait_done(4000, 1'b0);
    check("f2_accepts", frame_acc, NPIX);
    check("uf_sticky", 32'(underflow), 32'd1);
`ifdef FRAME_RD_UNDERFLOW_CNT_EN
    exp_ucnt = 10;
`else
    exp_ucnt = 0;
`endif
    check("uf_cnt", 32'(underflow_cnt), exp_ucnt);

    // Back-to-back frames with playback_en held, dropped during frame 2
    push_frame(3, 0, NPIX);
    push_frame(4, 0, NPIX);
    push_junk(3);
    @(negedge clk) playback_en = 1'b1;
    hit = 1'b0;
    for (int unsigned c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (frame_done) begin
        hit = 1'b1;
        break;
      end
    end
    check("b2b_first_done", 32'(hit), 32'd1);
    check("b2b_uf_cleared", 32'(underflow), 32'd0);
    check("b2b_f3_accepts", frame_acc, NPIX);
    @(negedge clk);
    check("b2b_req_next", 32'(frame_req), 32'd1);
    playback_en = 1'b0;
    wait_done(4000, 1'b0);
    check("b2b_f4_accepts", frame_acc, NPIX);
    check("b2b_req_cnt", req_cnt, 32'd5);
    check("b2b_extra_left", q.size(), 32'd3);
    repeat (4) @(negedge clk);
    check("b2b_idle_req", req_cnt, 32'd5);
    q.delete();
    fifo_empty = 1'b1;

    // Reset in the middle of a frame, then a clean restart
    push_frame(5, 0, NPIX);
    pulse_play();
    hit = 1'b0;
    for (int unsigned c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (pixel_valid && pixel_x == 8'd7 && pixel_y == 8'd3) begin
        hit = 1'b1;
        break;
      end
    end
    check("mid_reach_pix", 32'(hit), 32'd1);
    #1 resetn = 1'b0;
    #1 check_all_zero("mid");
    q.delete();
    fifo_empty = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    push_frame(6, 0, NPIX);
    pulse_play();
    wait_done(4000, 1'b0);
    check("rst_f6_accepts", frame_acc, NPIX);
    check("rst_f6_last_x", 32'(last_x), W - 1);
    check("rst_f6_last_y", 32'(last_y), H - 1);
    check("rst_req_cnt", req_cnt, 32'd7);
    check("rst_done_cnt", done_cnt, 32'd6);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
